// File: rtl/activation_unit_pkg.sv
// Shared fixed-point format constants, activation-type encodings and the
// sigmoid table generator used by the activation stage.
package activation_unit_pkg;

    // Default data format: signed Q(WI).(F), D bits wide
    localparam int D  = 16;
    localparam int WI = 4;
    localparam int F  = D - WI;
    localparam int SS = 10;

    // Activation function encodings
    localparam int RELU     = 0;
    localparam int SIG_FULL = 1;
    localparam int SIG_HALF = 2;

    // Table entry for signed slice value k: round-half-up(sigma(k * 2^-(ss-wi)) * 2^f).
    // Evaluated only at elaboration to fill the constant ROMs.
    function automatic int sigmoid_entry(input int k, input int ss, input int wi, input int f);
        real x;
        real s;
        x = real'(k) / (2.0 ** (ss - wi));
        s = 1.0 / (1.0 + $exp(-x));
        return $rtoi($floor(s * (2.0 ** f) + 0.5));
    endfunction

endpackage

// File: rtl/activation_unit_sigmoid_rom.sv
// Sigmoid lookup with a registered read. HALF=0 stores all 2^SS entries;
// HALF=1 stores only k >= 0 and reflects negative inputs as 2^F - H[|k|].
module sigmoid_rom
    import activation_unit_pkg::*;
#(
    parameter int SS   = 10,
    parameter int D    = 16,
    parameter int WI   = 4,
    parameter bit HALF = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic signed [SS-1:0] i_k,
    output logic [D-1:0]         o_data
);

    localparam int FB = D - WI;

    logic [D-1:0] r_data;

    generate
        if (HALF) begin : g_half
            localparam int N = 2 ** (SS - 1);
            localparam logic [D-1:0] ONE = D'(2 ** FB);

            logic [D-1:0]  w_rom [0:N-1];
            logic [SS-1:0] w_negk;
            logic [SS-2:0] w_addr;
            logic [D-1:0]  w_rd;
            logic [D-1:0]  w_sym;

            for (genvar i = 0; i < N; i++) begin : g_entry
                assign w_rom[i] = D'(sigmoid_entry(i, SS, WI, FB));
            end

            assign w_negk = {SS{1'b0}} - i_k;

            // Fold the signed index onto the stored half; the most negative k
            // has no positive twin, so it reuses the last entry.
            always_comb begin
                w_addr = i_k[SS-2:0];
                if (!i_k[SS-1]) begin
                    w_addr = i_k[SS-2:0];
                end else if (i_k == {1'b1, {(SS-1){1'b0}}}) begin
                    w_addr = {(SS-1){1'b1}};
                end else begin
                    w_addr = w_negk[SS-2:0];
                end
            end

            assign w_rd  = w_rom[w_addr];
            assign w_sym = ONE - w_rd;

            // Registered read with symmetry applied; holds when not enabled
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= {D{1'b0}};
                end else if (i_en) begin
                    r_data <= i_k[SS-1] ? w_sym : w_rd;
                end
            end
        end else begin : g_full
            localparam int N = 2 ** SS;

            logic [D-1:0]  w_rom [0:N-1];
            logic [SS-1:0] w_addr;

            for (genvar i = 0; i < N; i++) begin : g_entry
                assign w_rom[i] = D'(sigmoid_entry(i - N / 2, SS, WI, FB));
            end

            // k + 2^(SS-1) is the two's-complement value with its sign bit flipped
            assign w_addr = {~i_k[SS-1], i_k[SS-2:0]};

            // Registered read; holds when not enabled
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= {D{1'b0}};
                end else if (i_en) begin
                    r_data <= w_rom[w_addr];
                end
            end
        end
    endgenerate

    assign o_data = r_data;

endmodule

// File: rtl/activation_unit.sv
// Registered activation stage: converts a double-width accumulator sum into a
// single-width activation via ReLU or a sigmoid table, one cycle of latency.
module activation_unit
    import activation_unit_pkg::*;
#(
    parameter int DATA_WIDTH       = D,
    parameter int WEIGHT_INT_WIDTH = WI,
    parameter int SIGMOID_SIZE     = SS,
    parameter int ACT_TYPE         = SIG_HALF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [2*DATA_WIDTH-1:0]   sum,
    output logic [DATA_WIDTH-1:0]     out,
    output logic                      out_valid
);

    localparam int DW = DATA_WIDTH;
    localparam int W  = WEIGHT_INT_WIDTH;
    localparam int S  = SIGMOID_SIZE;

    logic          r_valid;
    logic [DW-1:0] w_act;

    // Valid pipeline: in_valid delayed by one cycle, dropped during reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
        end
    end

    generate
        if (ACT_TYPE == RELU) begin : g_relu
            logic [DW-1:0] w_relu;
            logic [DW-1:0] r_relu;
            logic          w_unused_bits;

            // Clamp negatives to zero and anything at or above 2^(WI-1) to
            // max positive; the output sign position is included in the
            // overflow test so truncation can never flip the sign.
            always_comb begin
                w_relu = sum[2*DW-1-W -: DW];
                if (sum[2*DW-1]) begin
                    w_relu = {DW{1'b0}};
                end else if (|sum[2*DW-2 -: W]) begin
                    w_relu = {1'b0, {(DW-1){1'b1}}};
                end else begin
                    w_relu = sum[2*DW-1-W -: DW];
                end
            end

            // Output register; holds its value between valid inputs
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_relu <= {DW{1'b0}};
                end else if (in_valid) begin
                    r_relu <= w_relu;
                end
            end

            assign w_unused_bits = ^sum[2*DW-1-W-DW:0];
            assign w_act         = r_relu;
        end else if ((ACT_TYPE == SIG_FULL) || (ACT_TYPE == SIG_HALF)) begin : g_sig
            logic [S-1:0]        w_slice;
            logic                w_ovf;
            logic signed [S-1:0] w_k;
            logic [DW-1:0]       w_rom_data;
            logic                w_unused_bits;

            assign w_slice = sum[2*DW-1-W -: S];
            assign w_ovf   = (sum[2*DW-1 -: W] != {W{sum[2*DW-1-W]}});

            // Table index: the slice, saturated to the table range on overflow
            always_comb begin
                w_k = w_slice;
                if (!w_ovf) begin
                    w_k = w_slice;
                end else if (sum[2*DW-1]) begin
                    w_k = {1'b1, {(S-1){1'b0}}};
                end else begin
                    w_k = {1'b0, {(S-1){1'b1}}};
                end
            end

            sigmoid_rom #(
                .SS   (S),
                .D    (DW),
                .WI   (W),
                .HALF (ACT_TYPE == SIG_HALF)
            ) u_sigmoid_rom (
                .clk    (clk),
                .rst    (rst),
                .i_en   (in_valid),
                .i_k    (w_k),
                .o_data (w_rom_data)
            );

            assign w_unused_bits = ^sum[2*DW-1-W-S:0];
            assign w_act         = w_rom_data;
        end else begin : g_bad
            $error("activation_unit: unsupported ACT_TYPE %0d", ACT_TYPE);
            assign w_act = {DW{1'b0}};
        end
    endgenerate

    assign out       = w_act;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_activation_unit.sv
// Scoreboard bench for activation_unit: ReLU, full-ROM and half-ROM instances
// share one stimulus stream; a monitor checks every output cycle.
module tb_activation_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] sum;

    logic [15:0] out_r, out_f, out_h;
    logic        ov_r, ov_f, ov_h;

    int total = 0;
    int bad   = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] last_v [3];

    logic exp_v   = 1'b0;
    logic exp_rst = 1'b0;

    logic [31:0] vec_sum  [8];
    logic [15:0] vec_relu [8];
    logic [15:0] vec_sig  [8];

    always #5 clk = ~clk;

    activation_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4), .SIGMOID_SIZE(10), .ACT_TYPE(0)) u_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_r), .out_valid(ov_r));
    activation_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4), .SIGMOID_SIZE(10), .ACT_TYPE(1)) u_full (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_f), .out_valid(ov_f));
    activation_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(4), .SIGMOID_SIZE(10), .ACT_TYPE(2)) u_half (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum), .out(out_h), .out_valid(ov_h));

    // Reference timing model: valid one cycle after input, cleared by reset
    always @(posedge clk) begin
        exp_v   <= rst ? 1'b0 : in_valid;
        exp_rst <= rst;
    end

    task automatic chk(input int idx, input logic [15:0] o, input logic v);
        logic [15:0] e;
        logic        have;
        have = 1'b0;
        e    = 16'h0000;
        total++;
        if (v !== exp_v) begin
            bad++;
            $display("FAIL valid[%0d] t=%0t got=%b exp=%b", idx, $time, v, exp_v);
        end
        if (exp_rst) last_v[idx] = 16'h0000;
        if (v === 1'b1) begin
            case (idx)
                0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            total++;
            if (!have) begin
                bad++;
                $display("FAIL stale[%0d] t=%0t got=%h exp=none", idx, $time, o);
            end else begin
                if (o !== e) begin
                    bad++;
                    $display("FAIL out[%0d] t=%0t got=%h exp=%h", idx, $time, o, e);
                end
                last_v[idx] = e;
            end
        end else begin
            total++;
            if (o !== last_v[idx]) begin
                bad++;
                $display("FAIL hold[%0d] t=%0t got=%h exp=%h", idx, $time, o, last_v[idx]);
            end
        end
    endtask

    // Monitor: sample all instances on the falling edge
    always @(negedge clk) begin
        chk(0, out_r, ov_r);
        chk(1, out_f, ov_f);
        chk(2, out_h, ov_h);
    end

    task automatic send(input logic [31:0] s, input logic [15:0] er, input logic [15:0] es);
        @(negedge clk);
        in_valid = 1'b1;
        sum      = s;
        q0.push_back(er);
        q1.push_back(es);
        q2.push_back(es);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            sum      = 32'h0000_0000;
        end
    endtask

    initial begin
        last_v[0] = 16'h0000;
        last_v[1] = 16'h0000;
        last_v[2] = 16'h0000;

        vec_sum[0] = 32'h0000_0000; vec_relu[0] = 16'h0000; vec_sig[0] = 16'd2048;
        vec_sum[1] = 32'h0100_0000; vec_relu[1] = 16'h1000; vec_sig[1] = 16'd2994;
        vec_sum[2] = 32'hFF00_0000; vec_relu[2] = 16'h0000; vec_sig[2] = 16'd1102;
        vec_sum[3] = 32'h0900_0000; vec_relu[3] = 16'h7FFF; vec_sig[3] = 16'd4095;
        vec_sum[4] = 32'hF000_0000; vec_relu[4] = 16'h0000; vec_sig[4] = 16'd1;
        vec_sum[5] = 32'h0040_0000; vec_relu[5] = 16'h0400; vec_sig[5] = 16'd2303;
        vec_sum[6] = 32'h07FF_F000; vec_relu[6] = 16'h7FFF; vec_sig[6] = 16'd4095;
        vec_sum[7] = 32'hFFFF_F000; vec_relu[7] = 16'h0000; vec_sig[7] = 16'd2032;

        rst      = 1'b1;
        in_valid = 1'b0;
        sum      = 32'h0000_0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Isolated cases with idle gaps to exercise output hold
        for (int i = 0; i < 8; i++) begin
            send(vec_sum[i], vec_relu[i], vec_sig[i]);
            idle(2);
        end

        // Back-to-back stream, then reset while inputs are still valid
        for (int i = 0; i < 8; i++) begin
            send(vec_sum[i], vec_relu[i], vec_sig[i]);
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        sum      = 32'h0100_0000;
        @(negedge clk);
        sum      = 32'h0900_0000;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        sum      = 32'h0000_0000;
        idle(6);

        total++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", q0.size() + q1.size() + q2.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
